// File: rtl/psum_drain_if.sv
// ---------------------------------------------------------------------------
// psum_drain_if
//   Bundles the psum_drain data path: the psum stream leaving the last PE
//   column (ENRight/psumRight), the aligned output vector handshake
//   (OValid/OReady/OData) and the status outputs (Overflow/VecCount).
//
//   Handshake: OData is offered while OValid=1 and a vector transfers on
//   every CLK rising edge where OValid=1 and OReady=1. Once raised, OValid
//   and OData hold until that transfer happens. OReady may be driven at
//   will and has no effect while OValid=0. ENRight has no ready: a push to
//   a full row is dropped and reported on Overflow.
//
//   Modports:
//     master : array edge / downstream side (drives ENRight, psumRight, OReady)
//     slave  : psum_drain itself (drives OValid, OData, Overflow, VecCount)
// ---------------------------------------------------------------------------
interface psum_drain_if #(
    parameter int ROWS   = 4,
    parameter int PSUM_W = 16
);
    logic [ROWS-1:0]        ENRight;
    logic [ROWS*PSUM_W-1:0] psumRight;
    logic                   OValid;
    logic                   OReady;
    logic [ROWS*PSUM_W-1:0] OData;
    logic [ROWS-1:0]        Overflow;
    logic [15:0]            VecCount;

    modport master (
        output ENRight, psumRight, OReady,
        input  OValid, OData, Overflow, VecCount
    );

    modport slave (
        input  ENRight, psumRight, OReady,
        output OValid, OData, Overflow, VecCount
    );
endinterface

// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
//   Right-edge collector of the weight-stationary MAC array. Each row has its
//   own FIFO so the skewed per-row psums can be realigned: a vector is
//   offered only once every row holds at least one entry, and all rows pop
//   together when the vector is accepted.
//
//   Ports:
//     CLK  : rising-edge clock
//     RST  : synchronous, active-high reset (drops all buffered psums)
//     bus  : psum_drain_if.slave
//              ENRight[r]/psumRight lane r : row r push
//              OValid/OReady/OData         : aligned vector handshake
//              Overflow[r]                 : sticky drop flag for row r
//              VecCount                    : accepted vectors, wraps at 2^16
// ---------------------------------------------------------------------------
module psum_drain #(
    parameter int ROWS   = 4,
    parameter int PSUM_W = 16,
    parameter int DEPTH  = 8
) (
    input logic         CLK,
    input logic         RST,
    psum_drain_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PSUM_W-1:0]      mem      [ROWS][DEPTH];
    logic [AW-1:0]          wr_ptr   [ROWS];
    logic [AW-1:0]          rd_ptr   [ROWS];
    logic [CW-1:0]          count    [ROWS];
    logic [ROWS-1:0]        row_nonempty;
    logic [ROWS-1:0]        row_full;
    logic [ROWS-1:0]        push_ok;
    logic [ROWS-1:0]        drop;
    logic                   out_valid;
    logic                   pop;
    logic [ROWS*PSUM_W-1:0] out_data;
    logic [ROWS-1:0]        overflow_q;
    logic [15:0]            vec_count_q;

    // Valid is built from registered counts only, so neither ENRight nor
    // OReady reaches OValid combinationally.
    always_comb begin
        row_nonempty = '0;
        row_full     = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_nonempty[r] = (count[r] != '0);
            row_full[r]     = (count[r] == CW'(DEPTH));
        end
    end

    assign out_valid = &row_nonempty;
    assign pop       = out_valid && bus.OReady;

    // A full row still accepts a push on a popping edge: the slot being
    // vacated is reused, so the count stays at DEPTH.
    always_comb begin
        push_ok = '0;
        drop    = '0;
        for (int r = 0; r < ROWS; r++) begin
            push_ok[r] = bus.ENRight[r] && (!row_full[r] || pop);
            drop[r]    = bus.ENRight[r] && row_full[r] && !pop;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < ROWS; r++) begin
            if (push_ok[r] && !RST) begin
                mem[r][wr_ptr[r]] <= bus.psumRight[r*PSUM_W +: PSUM_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < ROWS; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                count[r]  <= '0;
            end
            overflow_q  <= '0;
            vec_count_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (push_ok[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + AW'(1);
                end
                if (pop) begin
                    rd_ptr[r] <= rd_ptr[r] + AW'(1);
                end
                if (push_ok[r] && !pop) begin
                    count[r] <= count[r] + CW'(1);
                end else if (!push_ok[r] && pop) begin
                    count[r] <= count[r] - CW'(1);
                end
            end
            overflow_q <= overflow_q | drop;
            if (pop) begin
                vec_count_q <= vec_count_q + 16'd1;
            end
        end
    end

    // Heads are masked while no vector is offered so that OData reads zero
    // after reset instead of stale storage.
    always_comb begin
        out_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            out_data[r*PSUM_W +: PSUM_W] = out_valid ? mem[r][rd_ptr[r]] : '0;
        end
    end

    assign bus.OValid   = out_valid;
    assign bus.OData    = out_data;
    assign bus.Overflow = overflow_q;
    assign bus.VecCount = vec_count_q;
endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
    localparam int ROWS   = 4;
    localparam int PSUM_W = 16;
    localparam int DEPTH  = 8;
    localparam int VW     = ROWS * PSUM_W;

    logic CLK;
    logic RST;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_q[$];

    psum_drain_if #(.ROWS(ROWS), .PSUM_W(PSUM_W)) bus ();

    psum_drain #(.ROWS(ROWS), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [VW-1:0] pack4(input logic [PSUM_W-1:0] l0,
                                            input logic [PSUM_W-1:0] l1,
                                            input logic [PSUM_W-1:0] l2,
                                            input logic [PSUM_W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Row r pushes in the r-th cycle; unused lanes carry junk.
    task automatic push_skewed(input logic [VW-1:0] v);
        for (int r = 0; r < ROWS; r++) begin
            bus.ENRight   = ROWS'(1) << r;
            bus.psumRight = {$urandom, $urandom};
            bus.psumRight[r*PSUM_W +: PSUM_W] = v[r*PSUM_W +: PSUM_W];
            cycle();
        end
        bus.ENRight = '0;
    endtask

    task automatic push_aligned(input logic [ROWS-1:0] mask, input logic [VW-1:0] v);
        bus.ENRight   = mask;
        bus.psumRight = v;
        cycle();
        bus.ENRight   = '0;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (!RST && bus.OValid && bus.OReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector: got %h expected none", bus.OData);
            end else begin
                chk("odata", bus.OData, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [VW-1:0] v0, v1, v2, x;

    initial begin
        RST           = 1'b1;
        bus.ENRight   = '0;
        bus.psumRight = '0;
        bus.OReady    = 1'b0;
        cycle();
        cycle();
        RST = 1'b0;
        chk("reset_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("reset_odata", bus.OData, '0);
        chk("reset_overflow", VW'(bus.Overflow), '0);
        chk("reset_veccount", VW'(bus.VecCount), '0);

        // Skewed single vector, OReady high throughout
        bus.OReady = 1'b1;
        v0 = pack4(16'd10, 16'hFFEC, 16'd300, 16'h8000);
        exp_q.push_back(v0);
        push_skewed(v0);
        chk("single_ovalid_rise", VW'(bus.OValid), VW'(1'b1));
        chk("single_odata", bus.OData, v0);
        cycle();
        chk("single_ovalid_fall", VW'(bus.OValid), VW'(1'b0));
        chk("single_veccount", VW'(bus.VecCount), VW'(16'd1));
        chk("single_overflow", VW'(bus.Overflow), '0);

        // Back-pressure hold
        bus.OReady = 1'b0;
        v0 = pack4(16'h1111, 16'h1112, 16'h1113, 16'h1114);
        v1 = pack4(16'h2221, 16'hF222, 16'h2223, 16'h2224);
        v2 = pack4(16'h3331, 16'h3332, 16'h8333, 16'h3334);
        exp_q.push_back(v0);
        exp_q.push_back(v1);
        exp_q.push_back(v2);
        push_skewed(v0);
        chk("hold_ovalid", VW'(bus.OValid), VW'(1'b1));
        push_skewed(v1);
        chk("hold_odata_after_v1", bus.OData, v0);
        push_skewed(v2);
        chk("hold_odata_after_v2", bus.OData, v0);
        bus.OReady = 1'b1;
        repeat (3) cycle();
        chk("hold_drained_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("hold_veccount", VW'(bus.VecCount), VW'(16'd4));
        bus.OReady = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            x = pack4(16'h4000 + 16'(i), 16'h4100 + 16'(i), 16'h4200 + 16'(i), 16'hC300 + 16'(i));
            exp_q.push_back(x);
            push_aligned('1, x);
        end
        chk("full_ovalid", VW'(bus.OValid), VW'(1'b1));
        x = pack4(16'h4888, 16'h4999, 16'h4AAA, 16'h4BBB);
        exp_q.push_back(x);
        bus.OReady = 1'b1;
        push_aligned('1, x);
        bus.OReady = 1'b0;
        chk("full_pushpop_overflow", VW'(bus.Overflow), '0);
        bus.OReady = 1'b1;
        repeat (DEPTH) cycle();
        bus.OReady = 1'b0;
        chk("full_drained_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("full_veccount", VW'(bus.VecCount), VW'(16'd13));

        // Overflow on row 2 only
        for (int i = 0; i < DEPTH; i++) begin
            push_aligned(4'b0100, pack4(16'h0400 + 16'(i), 16'h0410 + 16'(i),
                                        16'h0200 + 16'(i), 16'h0430 + 16'(i)));
        end
        chk("ovf_before", VW'(bus.Overflow), '0);
        push_aligned(4'b0100, pack4(16'h0999, 16'h0999, 16'h0999, 16'h0999));
        chk("ovf_flag", VW'(bus.Overflow), VW'(4'b0100));
        for (int i = 0; i < DEPTH; i++) begin
            x = pack4(16'h0400 + 16'(i), 16'h0410 + 16'(i), 16'h0200 + 16'(i), 16'h0430 + 16'(i));
            exp_q.push_back(x);
            push_aligned(4'b1011, x);
        end
        bus.OReady = 1'b1;
        repeat (DEPTH) cycle();
        bus.OReady = 1'b0;
        chk("ovf_drained_ovalid", VW'(bus.OValid), VW'(1'b0));
        // Row 2 must now be empty: the dropped 9th value must not complete this vector.
        x = pack4(16'h0501, 16'h0502, 16'h0503, 16'h0504);
        push_aligned(4'b1011, x);
        chk("ovf_row2_empty", VW'(bus.OValid), VW'(1'b0));
        exp_q.push_back(x);
        bus.OReady = 1'b1;
        push_aligned(4'b0100, x);
        cycle();
        bus.OReady = 1'b0;
        chk("ovf_veccount", VW'(bus.VecCount), VW'(16'd22));
        chk("ovf_sticky", VW'(bus.Overflow), VW'(4'b0100));

        // Reset mid-stream: rows 0-1 hold two entries, rows 2-3 hold one
        push_aligned('1, pack4(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
        push_aligned(4'b0011, pack4(16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03));
        chk("rst_pre_ovalid", VW'(bus.OValid), VW'(1'b1));
        pulse_reset();
        chk("rst_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("rst_odata", bus.OData, '0);
        chk("rst_veccount", VW'(bus.VecCount), '0);
        chk("rst_overflow", VW'(bus.Overflow), '0);
        x = pack4(16'h0C00, 16'hFC01, 16'h0C02, 16'h7C03);
        exp_q.push_back(x);
        bus.OReady = 1'b1;
        push_skewed(x);
        cycle();
        chk("rst_fresh_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("rst_fresh_veccount", VW'(bus.VecCount), VW'(16'd1));

        // Wrap: 70000 aligned vectors, lane value = sequence index
        pulse_reset();
        bus.OReady = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            x = {ROWS{16'(i)}};
            exp_q.push_back(x);
            bus.ENRight   = '1;
            bus.psumRight = x;
            cycle();
        end
        bus.ENRight = '0;
        cycle();
        bus.OReady = 1'b0;
        chk("wrap_veccount", VW'(bus.VecCount), VW'(16'd4464));
        chk("wrap_ovalid", VW'(bus.OValid), VW'(1'b0));
        chk("wrap_overflow", VW'(bus.Overflow), '0);
        chk("scoreboard_empty", VW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
